// File: rtl/rr_arbiter_dc_if.sv
// Request/grant bundle for rr_arbiter_dc.
//   inReq      [7:0]  level-sensitive request lines, bit n = requester n
//   outGnt     [7:0]  one-hot grant, zero when no grant is active
//   outIdx     [2:0]  binary index of the granted requester (valid with outValid)
//   outValid          high while a grant is active
//   outTimeout        one-cycle pulse when a grant is force-released on hold expiry
// Modports:
//   master  requester side (drives inReq, observes the grant)
//   slave   arbiter side (samples inReq, drives the grant)
interface rr_arbiter_dc_if;
  logic [7:0] inReq;
  logic [7:0] outGnt;
  logic [2:0] outIdx;
  logic       outValid;
  logic       outTimeout;

  modport master (
    output inReq,
    input  outGnt,
    input  outIdx,
    input  outValid,
    input  outTimeout
  );

  modport slave (
    input  inReq,
    output outGnt,
    output outIdx,
    output outValid,
    output outTimeout
  );
endinterface

// File: rtl/rr_arbiter_dc.sv
// Eight-way round-robin arbiter with a mandatory one-cycle gap between grants.
// The search for the next requester starts at a rotating pointer that moves to
// one past the most recently released requester, so every requester is served
// in turn while requests stay asserted.
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter_dc_if.slave (inReq in; outGnt/outIdx/outValid/outTimeout out)
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles before forced release (1..255)
//
// Build option:
//   RR_ARBITER_TIMEOUT_EN  when defined, a grant still requested after HOLD_MAX
//                          cycles is released and outTimeout pulses during the gap.
//                          When undefined, grants last until the request drops and
//                          outTimeout stays 0.
module rr_arbiter_dc #(
  parameter int unsigned HOLD_MAX = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_dc_if.slave bus
);

  // Last grant cycle number before expiry; the counter starts at 0 on entry.
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic       timeout_q;

  // Rotating priority search: first set request at or above ptr_q, modulo 8.
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + i[2:0];
      if (!sel_found && bus.inReq[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Current holder's request line, sampled only in StGrant.
  logic holder_req;
  assign holder_req = bus.inReq[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 8'h00;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // The timeout flag is a pulse: only the releasing edge sets it.
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            state_q <= StGrant;
            idx_q   <= sel_idx;
            gnt_q   <= 8'h01 << sel_idx;
            valid_q <= 1'b1;
            hold_q  <= 8'd0;
          end
        end
        StGrant: begin
          if (!holder_req) begin
            // A drop on the expiry cycle lands here too, so it is a normal release.
            state_q <= StGap;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            hold_q  <= 8'd0;
            ptr_q   <= idx_q + 3'd1;
`ifdef RR_ARBITER_TIMEOUT_EN
          end else if (hold_q == HoldLast) begin
            state_q   <= StGap;
            gnt_q     <= 8'h00;
            valid_q   <= 1'b0;
            hold_q    <= 8'd0;
            ptr_q     <= idx_q + 3'd1;
            timeout_q <= 1'b1;
`endif
          end else if (hold_q != HoldLast) begin
            // Saturates at HoldLast so a long hold never wraps back to 0.
            hold_q <= hold_q + 8'd1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 8'h00;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outGnt     = gnt_q;
  assign bus.outIdx     = idx_q;
  assign bus.outValid   = valid_q;
  assign bus.outTimeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_dc.sv
// Directed bench for rr_arbiter_dc. Stimulus pushes the expected grant order
// into a queue; a negedge monitor pops it on each new grant and also checks the
// one-hot/idle invariants and counts timeout pulses.
module tb_rr_arbiter_dc;
  localparam int unsigned HoldMax = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_arbiter_dc_if bus ();

  rr_arbiter_dc #(.HOLD_MAX(HoldMax)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp_timeouts = 0;
  int seen_timeouts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic       prev_valid = 1'b0;
  logic [2:0] prev_idx = 3'd0;
  int         e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("valid_vs_gnt", {31'd0, bus.outValid}, {31'd0, (bus.outGnt != 8'h00)});
      if (bus.outValid) check("gnt_onehot", {31'd0, $onehot(bus.outGnt)}, 32'd1);
      if (bus.outValid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%0d required=none at %0t", bus.outIdx, $time);
        end else begin
          e_mon = exp_q.pop_front();
          check("grant_idx", {29'd0, bus.outIdx}, e_mon);
          check("grant_gnt", {24'd0, bus.outGnt}, 32'd1 << e_mon);
        end
      end
      if (bus.outValid && prev_valid) check("grant_stable", {29'd0, bus.outIdx}, {29'd0, prev_idx});
      if (bus.outTimeout) begin
        seen_timeouts++;
        check("timeout_in_gap", {31'd0, bus.outValid}, 32'd0);
      end
      prev_valid = bus.outValid;
      prev_idx   = bus.outIdx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.outValid && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, bus.outValid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {24'd0, bus.outGnt}, 32'h00);
    check({tag, "_valid"}, {31'd0, bus.outValid}, 32'd0);
    check({tag, "_idx"}, {29'd0, bus.outIdx}, 32'd0);
    check({tag, "_timeout"}, {31'd0, bus.outTimeout}, 32'd0);
  endtask

  initial begin
    int n;
    int e;

    // Reset with every requester asserted.
    bus.inReq = 8'hFF;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: each requester holds two cycles, drops, then reasserts.
    for (int g = 0; g < 9; g++) exp_q.push_back(g % 8);
    for (int g = 0; g < 9; g++) begin
      e = g % 8;
      wait_valid("fair_valid");
      tick();
      check("fair_second_cycle", {31'd0, bus.outValid}, 32'd1);
      bus.inReq[e] = 1'b0;
      tick();
      check("fair_gap", {31'd0, bus.outValid}, 32'd0);
      bus.inReq = (g == 8) ? 8'h00 : 8'hFF;
    end
    tick();
    tick();

    // Pointer wrap: grant 5 leaves ptr at 6, so 8'h21 picks 0 first, then 5.
    exp_q.push_back(5);
    exp_q.push_back(0);
    exp_q.push_back(5);
    bus.inReq = 8'h20;
    wait_valid("wrap_first");
    tick();
    bus.inReq = 8'h00;
    tick();
    bus.inReq = 8'h21;
    wait_valid("wrap_second");
    check("wrap_gnt0", {24'd0, bus.outGnt}, 32'h01);
    tick();
    bus.inReq = 8'h20;
    tick();
    wait_valid("wrap_third");
    check("wrap_gnt5", {24'd0, bus.outGnt}, 32'h20);
    bus.inReq = 8'h00;
    tick();
    tick();

    // Latency: idle, request 3 appears, grant exactly one edge later.
    exp_q.push_back(3);
    bus.inReq = 8'h08;
    check("lat_before_edge", {31'd0, bus.outValid}, 32'd0);
    tick();
    check("lat_valid", {31'd0, bus.outValid}, 32'd1);
    check("lat_idx", {29'd0, bus.outIdx}, 32'd3);
    check("lat_gnt", {24'd0, bus.outGnt}, 32'h08);
    bus.inReq = 8'hFF;
    tick();
    check("lat_toggle_a", {24'd0, bus.outGnt}, 32'h08);
    bus.inReq = 8'h0C;
    tick();
    check("lat_toggle_b", {24'd0, bus.outGnt}, 32'h08);
    bus.inReq = 8'hF7;
    tick();
    check("lat_release", {31'd0, bus.outValid}, 32'd0);
    check("lat_release_to", {31'd0, bus.outTimeout}, 32'd0);
    bus.inReq = 8'h00;

`ifdef RR_ARBITER_TIMEOUT_EN
    // ptr=4: 8'h03 held -> idx 0 for HoldMax cycles, forced out, then idx 1.
    exp_timeouts = 1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    bus.inReq = 8'h03;
    wait_valid("to_first");
    n = 0;
    while (bus.outValid && n < 20) begin
      tick();
      n++;
    end
    check("to_hold_cycles", n, HoldMax);
    check("to_pulse", {31'd0, bus.outTimeout}, 32'd1);
    tick();
    check("to_pulse_end", {31'd0, bus.outTimeout}, 32'd0);
    wait_valid("to_second");
    bus.inReq = 8'h00;
    tick();
    check("to_normal_release", {31'd0, bus.outTimeout}, 32'd0);

    // Drop on the expiry cycle is a normal release.
    exp_q.push_back(2);
    bus.inReq = 8'h04;
    wait_valid("to_simul");
    tick();
    tick();
    tick();
    bus.inReq = 8'h00;
    tick();
    check("to_simul_valid", {31'd0, bus.outValid}, 32'd0);
    check("to_simul_pulse", {31'd0, bus.outTimeout}, 32'd0);
`else
    // No timeout: idx 0 stays granted well past HoldMax cycles.
    exp_timeouts = 0;
    exp_q.push_back(0);
    bus.inReq = 8'h03;
    wait_valid("hold_first");
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_gnt", {24'd0, bus.outGnt}, 32'h01);
      check("hold_no_to", {31'd0, bus.outTimeout}, 32'd0);
    end
    bus.inReq = 8'h00;
    tick();
    check("hold_release", {31'd0, bus.outValid}, 32'd0);
    check("hold_release_to", {31'd0, bus.outTimeout}, 32'd0);
`endif
    tick();

    // Mid-grant reset drops the grant without waiting for a clock edge.
    exp_q.push_back(4);
    bus.inReq = 8'h10;
    wait_valid("mid_first");
    tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.push_back(4);
    wait_valid("mid_regrant");
    check("mid_regrant_gnt", {24'd0, bus.outGnt}, 32'h10);

    // Release leaves ptr=5; a reset must return it to 0 so 8'h21 picks 0.
    bus.inReq = 8'h00;
    tick();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.push_back(0);
    bus.inReq = 8'h21;
    wait_valid("ptr_reset");
    check("ptr_reset_gnt", {24'd0, bus.outGnt}, 32'h01);
    bus.inReq = 8'h00;
    tick();
    tick();
    tick();

    check("exp_queue_empty", exp_q.size(), 32'd0);
    check("timeout_count", seen_timeouts, exp_timeouts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
